// File: rtl/sp_tracker_pno_if.sv
// Signal bundle between the tracker core and its ADC front-end, mode/jog inputs and servo pins.
// The bench or system side is master; the tracker core is slave.
interface sp_tracker_pno_if #(
  parameter int ADC_W    = 12,
  parameter int NUM_AXES = 2,
  parameter int POS_W    = 8,
  parameter int AXIS_W   = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1
);
  logic [ADC_W-1:0]          V_in;
  logic                      V_valid;
  logic                      MODE_AUTO;
  logic [NUM_AXES-1:0]       BTN_INC;
  logic [NUM_AXES-1:0]       BTN_DEC;
  logic [NUM_AXES-1:0]       SERVO;
  logic [NUM_AXES*POS_W-1:0] POS;
  logic [NUM_AXES-1:0]       DIR;
  logic [AXIS_W-1:0]         AXIS;
  logic [ADC_W-1:0]          max_V_in;
  logic [2:0]                STAT;

  modport master (
    output V_in, V_valid, MODE_AUTO, BTN_INC, BTN_DEC,
    input  SERVO, POS, DIR, AXIS, max_V_in, STAT
  );

  modport slave (
    input  V_in, V_valid, MODE_AUTO, BTN_INC, BTN_DEC,
    output SERVO, POS, DIR, AXIS, max_V_in, STAT
  );
endinterface

// File: rtl/sp_tracker_pno.sv
// N-axis solar tracker: perturb-and-observe hill-climb on panel voltage, one axis at a time,
// manual button jog when not in auto, and one glitch-free servo PWM per axis.
//
// state   | meaning
// IDLE    | manual jog; MODE_AUTO=1 starts a fresh auto run on axis 0
// MOVE    | step POS[AXIS] along DIR[AXIS], flip DIR on a clamped step
// SETTLE  | let the mount settle for SETTLE_CYC cycles
// SAMPLE  | wait for V_valid and latch V_in
// COMPARE | hill-climb decision, miss counting and axis advance
module sp_tracker_pno #(
  parameter int ADC_W      = 12,
  parameter int NUM_AXES   = 2,
  parameter int POS_W      = 8,
  parameter int STEP       = 1,
  parameter int HYST       = 8,
  parameter int SETTLE_CYC = 1_000_000,
  parameter int PWM_PERIOD = 2_000_000,
  parameter int PWM_MIN    = 100_000,
  parameter int PWM_SCALE  = 390
) (
  input  logic              CLK,
  input  logic              RST_N,
  sp_tracker_pno_if.slave   bus
);
  localparam int AXIS_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int ST_W   = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W  = $clog2(PWM_PERIOD);

  localparam logic [POS_W-1:0]  POS_MAX   = '1;
  localparam logic [POS_W-1:0]  POS_RST   = POS_W'(1) << (POS_W - 1);
  localparam logic [POS_W:0]    STEP_X    = (POS_W + 1)'(STEP);
  localparam logic [ADC_W:0]    HYST_X    = (ADC_W + 1)'(HYST);
  localparam logic [ST_W-1:0]   SETTLE_LD = ST_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0]  PMIN_C    = CNT_W'(PWM_MIN);
  localparam logic [CNT_W-1:0]  PSCALE_C  = CNT_W'(PWM_SCALE);
  localparam logic [AXIS_W-1:0] AXIS_LAST = AXIS_W'(NUM_AXES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_MOVE    = 3'b001,
    S_SETTLE  = 3'b010,
    S_SAMPLE  = 3'b011,
    S_COMPARE = 3'b100
  } state_t;

  state_t              state_q;
  logic [POS_W-1:0]    pos_q [NUM_AXES];
  logic [NUM_AXES-1:0] dir_q;
  logic [AXIS_W-1:0]   axis_q;
  logic [ADC_W-1:0]    max_q;
  logic [ADC_W-1:0]    sample_q;
  logic [1:0]          miss_q;
  logic                first_q;
  logic [ST_W-1:0]     settle_q;
  logic [NUM_AXES-1:0] inc_q, dec_q, inc_rise, dec_rise;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cmp_q [NUM_AXES];
  logic [CNT_W-1:0]    cmp_d [NUM_AXES];
  logic [NUM_AXES-1:0] servo_q;
  logic [NUM_AXES*POS_W-1:0] pos_flat;
  logic                better;

  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p, input logic up);
    logic [POS_W:0] px;
    px = {1'b0, p};
    if (up) return (px + STEP_X > {1'b0, POS_MAX}) ? POS_MAX : POS_W'(px + STEP_X);
    else    return (px < STEP_X) ? '0 : POS_W'(px - STEP_X);
  endfunction

  function automatic logic pos_clamps(input logic [POS_W-1:0] p, input logic up);
    logic [POS_W:0] px;
    px = {1'b0, p};
    return up ? (px + STEP_X > {1'b0, POS_MAX}) : (px < STEP_X);
  endfunction

  assign inc_rise = bus.BTN_INC & ~inc_q;
  assign dec_rise = bus.BTN_DEC & ~dec_q;
  // One extra bit so max + HYST cannot wrap near full scale.
  assign better   = {1'b0, sample_q} > ({1'b0, max_q} + HYST_X);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      for (int k = 0; k < NUM_AXES; k++) pos_q[k] <= POS_RST;
      dir_q    <= '1;
      axis_q   <= '0;
      max_q    <= '0;
      sample_q <= '0;
      miss_q   <= '0;
      first_q  <= 1'b1;
      settle_q <= '0;
    end else if (state_q != S_IDLE && !bus.MODE_AUTO) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.MODE_AUTO) begin
            first_q <= 1'b1;
            miss_q  <= '0;
            axis_q  <= '0;
            state_q <= S_MOVE;
          end else begin
            for (int k = 0; k < NUM_AXES; k++) begin
              if (inc_rise[k] && !dec_rise[k])      pos_q[k] <= pos_step(pos_q[k], 1'b1);
              else if (dec_rise[k] && !inc_rise[k]) pos_q[k] <= pos_step(pos_q[k], 1'b0);
            end
          end
        end
        S_MOVE: begin
          pos_q[axis_q] <= pos_step(pos_q[axis_q], dir_q[axis_q]);
          if (pos_clamps(pos_q[axis_q], dir_q[axis_q])) dir_q[axis_q] <= ~dir_q[axis_q];
          settle_q <= SETTLE_LD;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) state_q <= S_SAMPLE;
          else                settle_q <= settle_q - ST_W'(1);
        end
        S_SAMPLE: begin
          if (bus.V_valid) begin
            sample_q <= bus.V_in;
            state_q  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          state_q <= S_MOVE;
          if (first_q) begin
            max_q   <= sample_q;
            first_q <= 1'b0;
            miss_q  <= '0;
          end else if (better) begin
            max_q  <= sample_q;
            miss_q <= '0;
          end else begin
            dir_q[axis_q] <= ~dir_q[axis_q];
            if (miss_q == 2'd1) begin
              miss_q <= '0;
              axis_q <= (axis_q == AXIS_LAST) ? '0 : axis_q + AXIS_W'(1);
            end else begin
              miss_q <= miss_q + 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inc_q <= '0;
      dec_q <= '0;
    end else begin
      inc_q <= bus.BTN_INC;
      dec_q <= bus.BTN_DEC;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_AXES; k++) cmp_d[k] = PMIN_C + CNT_W'(pos_q[k]) * PSCALE_C;
  end

  // Compare values are only reloaded at counter 0 so a pulse is never cut or stretched mid-frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      servo_q <= '0;
      for (int k = 0; k < NUM_AXES; k++) cmp_q[k] <= '0;
    end else begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      for (int k = 0; k < NUM_AXES; k++) begin
        if (cnt_q == '0) begin
          cmp_q[k]   <= cmp_d[k];
          servo_q[k] <= cnt_q < cmp_d[k];
        end else begin
          servo_q[k] <= cnt_q < cmp_q[k];
        end
      end
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int k = 0; k < NUM_AXES; k++) pos_flat[k*POS_W +: POS_W] = pos_q[k];
  end

  assign bus.POS      = pos_flat;
  assign bus.SERVO    = servo_q;
  assign bus.DIR      = dir_q;
  assign bus.AXIS     = axis_q;
  assign bus.max_V_in = max_q;
  assign bus.STAT     = state_q;
endmodule

// File: tb/tb_sp_tracker_pno.sv
// Bench for sp_tracker_pno: directed scenarios plus a randomized phase, all checked every
// cycle against an integer-level model of the tracker rules.
module tb_sp_tracker_pno;
  localparam int ADC_W = 12, NA = 2, PW = 4, HY = 2, SC = 4, PP = 64, PMIN = 8, PSC = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_tracker_pno_if #(.ADC_W(ADC_W), .NUM_AXES(NA), .POS_W(PW)) bus ();

  sp_tracker_pno #(
    .ADC_W(ADC_W), .NUM_AXES(NA), .POS_W(PW), .STEP(1), .HYST(HY), .SETTLE_CYC(SC),
    .PWM_PERIOD(PP), .PWM_MIN(PMIN), .PWM_SCALE(PSC)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  int m_state, m_axis, m_max, m_first, m_miss, m_settle, m_sample, m_fc;
  int m_pos [NA];
  int m_dir [NA];
  int m_width [NA];
  int m_servo [NA];
  logic [NA-1:0] m_pin, m_pdn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_axis = 0; m_max = 0; m_first = 1; m_miss = 0; m_settle = 0;
    m_sample = 0; m_fc = 0; m_pin = '0; m_pdn = '0;
    for (int k = 0; k < NA; k++) begin
      m_pos[k] = 1 << (PW - 1); m_dir[k] = 1; m_width[k] = 0; m_servo[k] = 0;
    end
  endtask

  task automatic model_step();
    int c, np;
    logic [NA-1:0] ri, rd;
    c = m_fc;
    for (int k = 0; k < NA; k++) begin
      if (c == 0) m_width[k] = PMIN + PSC * m_pos[k];
      m_servo[k] = (c < m_width[k]) ? 1 : 0;
    end
    m_fc = (c + 1) % PP;
    ri = bus.BTN_INC & ~m_pin;
    rd = bus.BTN_DEC & ~m_pdn;
    m_pin = bus.BTN_INC;
    m_pdn = bus.BTN_DEC;
    if (m_state != 0 && !bus.MODE_AUTO) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: begin
          if (bus.MODE_AUTO) begin
            m_first = 1; m_miss = 0; m_axis = 0; m_state = 1;
          end else begin
            for (int k = 0; k < NA; k++) begin
              if (ri[k] && !rd[k])      m_pos[k] = (m_pos[k] + 1 > PMAX) ? PMAX : m_pos[k] + 1;
              else if (rd[k] && !ri[k]) m_pos[k] = (m_pos[k] - 1 < 0) ? 0 : m_pos[k] - 1;
            end
          end
        end
        1: begin
          np = m_pos[m_axis] + ((m_dir[m_axis] == 1) ? 1 : -1);
          if (np > PMAX) begin np = PMAX; m_dir[m_axis] = 1 - m_dir[m_axis]; end
          else if (np < 0) begin np = 0; m_dir[m_axis] = 1 - m_dir[m_axis]; end
          m_pos[m_axis] = np;
          m_settle = 0;
          m_state = 2;
        end
        2: begin
          m_settle++;
          if (m_settle == SC) m_state = 3;
        end
        3: if (bus.V_valid) begin m_sample = int'(bus.V_in); m_state = 4; end
        default: begin
          if (m_first == 1) begin
            m_max = m_sample; m_first = 0; m_miss = 0;
          end else if (m_sample > m_max + HY) begin
            m_max = m_sample; m_miss = 0;
          end else begin
            m_dir[m_axis] = 1 - m_dir[m_axis];
            m_miss++;
            if (m_miss == 2) begin m_miss = 0; m_axis = (m_axis + 1) % NA; end
          end
          m_state = 1;
        end
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("STAT",  32'(bus.STAT),     32'(m_state));
        chk("POS",   32'(bus.POS),      32'(m_pos[1] * 16 + m_pos[0]));
        chk("DIR",   32'(bus.DIR),      32'(m_dir[1] * 2 + m_dir[0]));
        chk("AXIS",  32'(bus.AXIS),     32'(m_axis));
        chk("MAXV",  32'(bus.max_V_in), 32'(m_max));
        chk("SERVO", 32'(bus.SERVO),    32'(m_servo[1] * 2 + m_servo[0]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic jog(input int ax, input bit inc);
    if (inc) bus.BTN_INC[ax] = 1'b1; else bus.BTN_DEC[ax] = 1'b1;
    cyc(1);
    bus.BTN_INC = '0; bus.BTN_DEC = '0;
    cyc(1);
  endtask

  task automatic wait_stat(input int s, input int budget, input string nm);
    for (int i = 0; i < budget && int'(bus.STAT) != s; i++) @(negedge clk);
    chk(nm, 32'(bus.STAT), 32'(s));
  endtask

  initial begin
    int hi0, hi1, n, ns, last, v;
    int stat_seen [7];
    int stat_exp [7] = '{1, 2, 2, 2, 2, 3, 4};
    int flat_v [5] = '{500, 500, 500, 502, 503};
    int mx_q [$];

    bus.V_in = '0; bus.V_valid = 1'b0; bus.MODE_AUTO = 1'b0;
    bus.BTN_INC = '0; bus.BTN_DEC = '0;
    cyc(2);
    chk("rst_pos",   32'(bus.POS),   32'h88);
    chk("rst_dir",   32'(bus.DIR),   32'h3);
    chk("rst_stat",  32'(bus.STAT),  32'h0);
    chk("rst_servo", 32'(bus.SERVO), 32'h0);
    rst_n = 1'b1;

    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      hi0 += int'(bus.SERVO[0]); hi1 += int'(bus.SERVO[1]);
    end
    chk("pwm_width0", 32'(hi0), 32'd24);
    chk("pwm_width1", 32'(hi1), 32'd24);

    // Manual jog
    bus.BTN_INC[0] = 1'b1; cyc(3); bus.BTN_INC = '0; cyc(2);
    chk("jog_held", 32'(bus.POS[3:0]), 32'd9);
    bus.BTN_INC[1] = 1'b1; bus.BTN_DEC[1] = 1'b1; cyc(2);
    bus.BTN_INC = '0; bus.BTN_DEC = '0; cyc(2);
    chk("jog_both", 32'(bus.POS[7:4]), 32'd8);
    jog(0, 1'b0);
    chk("jog_dec", 32'(bus.POS[3:0]), 32'd8);
    repeat (10) jog(0, 1'b1);
    chk("jog_sat", 32'(bus.POS[3:0]), 32'd15);
    repeat (7) jog(0, 1'b0);
    chk("jog_back", 32'(bus.POS), 32'h88);

    // Auto climb with V_in = 50*POS0
    bus.MODE_AUTO = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      stat_seen[i] = int'(bus.STAT);
      bus.V_valid = (m_state == 3);
      bus.V_in = 12'(50 * m_pos[0]);
    end
    for (int i = 0; i < 7; i++) chk("climb_stat_seq", 32'(stat_seen[i]), 32'(stat_exp[i]));
    last = 0; n = 0;
    while (bus.AXIS != 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (int'(bus.max_V_in) != last) begin last = int'(bus.max_V_in); mx_q.push_back(last); end
      bus.V_valid = (m_state == 3);
      bus.V_in = 12'(50 * m_pos[0]);
    end
    bus.V_valid = 1'b0;
    chk("climb_axis", 32'(bus.AXIS), 32'd1);
    chk("climb_nmax", 32'(mx_q.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      chk("climb_max_seq", 32'((i < mx_q.size()) ? mx_q[i] : 0), 32'(450 + 50 * i));
    chk("climb_pos", 32'(bus.POS), 32'h8F);
    chk("climb_max", 32'(bus.max_V_in), 32'd750);
    chk("climb_dir", 32'(bus.DIR), 32'h3);
    bus.MODE_AUTO = 1'b0; cyc(2);

    // Flat input, then hysteresis boundary on axis 1
    repeat (7) jog(0, 1'b0);
    chk("flat_start_pos", 32'(bus.POS), 32'h88);
    bus.MODE_AUTO = 1'b1;
    ns = 0; n = 0;
    while (!(ns == 5 && m_state == 1) && n < 200) begin
      @(negedge clk);
      n++;
      if (m_state == 3 && ns < 5) begin
        if (ns == 1) chk("flat_first_max", 32'(bus.max_V_in), 32'd500);
        if (ns == 3) chk("flat_axis_adv", 32'(bus.AXIS), 32'd1);
        if (ns == 4) begin
          chk("hyst_502_max", 32'(bus.max_V_in), 32'd500);
          chk("hyst_502_dir", 32'(bus.DIR), 32'h1);
        end
        bus.V_valid = 1'b1; bus.V_in = 12'(flat_v[ns]); ns++;
      end else begin
        bus.V_valid = 1'b0;
      end
    end
    bus.V_valid = 1'b0;
    chk("hyst_503_max", 32'(bus.max_V_in), 32'd503);
    chk("flat_pos", 32'(bus.POS), 32'h89);
    chk("flat_stat", 32'(bus.STAT), 32'd1);
    bus.MODE_AUTO = 1'b0; cyc(2);

    // MODE_AUTO dropped in SETTLE
    bus.MODE_AUTO = 1'b1;
    wait_stat(2, 20, "drop_enter_settle");
    bus.MODE_AUTO = 1'b0;
    cyc(1);
    chk("drop_stat", 32'(bus.STAT), 32'd0);
    chk("drop_pos", 32'(bus.POS), 32'h8A);
    bus.V_valid = 1'b1; bus.V_in = 12'd4000; cyc(1);
    bus.V_valid = 1'b0; cyc(2);
    chk("drop_vvalid_stat", 32'(bus.STAT), 32'd0);
    chk("drop_vvalid_max", 32'(bus.max_V_in), 32'd503);

    // POS change mid-frame
    for (int i = 0; i < 70 && m_fc != 1; i++) @(negedge clk);
    hi0 = 0;
    for (int j = 0; j < 64; j++) begin
      hi0 += int'(bus.SERVO[0]);
      if (j == 30) bus.BTN_INC[0] = 1'b1;
      @(negedge clk);
    end
    hi1 = 0;
    for (int j = 0; j < 64; j++) begin
      hi1 += int'(bus.SERVO[0]);
      if (j == 0) bus.BTN_INC = '0;
      @(negedge clk);
    end
    chk("pwm_frame_old", 32'(hi0), 32'd28);
    chk("pwm_frame_new", 32'(hi1), 32'd30);
    chk("pwm_pos", 32'(bus.POS[3:0]), 32'd11);

    // Asynchronous reset mid-SETTLE
    bus.MODE_AUTO = 1'b1;
    wait_stat(2, 20, "arst_enter_settle");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pos",   32'(bus.POS),      32'h88);
    chk("arst_max",   32'(bus.max_V_in), 32'd0);
    chk("arst_stat",  32'(bus.STAT),     32'd0);
    chk("arst_servo", 32'(bus.SERVO),    32'd0);
    chk("arst_dir",   32'(bus.DIR),      32'h3);
    chk("arst_axis",  32'(bus.AXIS),     32'd0);
    cyc(2);
    bus.MODE_AUTO = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.MODE_AUTO = ~bus.MODE_AUTO;
      for (int k = 0; k < NA; k++) begin
        if ($urandom_range(0, 3) == 0) bus.BTN_INC[k] = ~bus.BTN_INC[k];
        if ($urandom_range(0, 3) == 0) bus.BTN_DEC[k] = ~bus.BTN_DEC[k];
      end
      bus.V_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 4095));
      else v = m_max + int'($urandom_range(0, 8)) - 3;
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
      bus.V_in = 12'(v);
    end
    bus.V_valid = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sp_tracker_pno.md
# sp_tracker_pno

Parametrised solar-panel tracker core for an N-axis servo mount, and the successor to the two-axis `sp_optimizer`. In auto mode it runs a perturb-and-observe hill-climb on panel voltage, one axis at a time, with a settle delay and a hysteresis band. In manual mode each axis is jogged by button edges. It drives one glitch-free servo PWM output per axis and sits between the ADC front-end and the servo pins.

## Interface
Parameters:
- ADC_W, 12, panel-voltage sample width
- NUM_AXES, 2, number of servo axes (≥1)
- POS_W, 8, position register width per axis
- STEP, 1, position increment per perturbation or jog
- HYST, 8, comparison dead-band in ADC LSBs
- SETTLE_CYC, 1_000_000, wait after a move before sampling (≥1)
- PWM_PERIOD, 2_000_000, servo frame length in CLK cycles
- PWM_MIN, 100_000, pulse width at position 0
- PWM_SCALE, 390, extra pulse cycles per position LSB; PWM_MIN + (2^POS_W−1)·PWM_SCALE < PWM_PERIOD

Ports:
- CLK  in  1  system clock; reset is asynchronous and active-low
- RST_N  in  1  asynchronous active-low reset
- V_in  in  ADC_W  panel voltage sample
- V_valid  in  1  V_in qualifier, one-cycle strobe
- MODE_AUTO  in  1  1 = auto hill-climb, 0 = manual jog
- BTN_INC  in  NUM_AXES  per-axis increment button, pre-synchronised
- BTN_DEC  in  NUM_AXES  per-axis decrement button, pre-synchronised
- SERVO  out  NUM_AXES  per-axis PWM output
- POS  out  NUM_AXES·POS_W  packed positions; axis k at [k·POS_W +: POS_W]
- DIR  out  NUM_AXES  per-axis search direction, 1 = increasing
- AXIS  out  max(1,$clog2(NUM_AXES))  axis currently being optimised
- max_V_in  out  ADC_W  best sample held in the current auto run
- STAT  out  3  FSM state

## Operation
- Reset values:
  - POS[k] = 2^(POS_W−1)
  - DIR = all 1s
  - AXIS = 0
  - max_V_in = 0
  - STAT = 000 (IDLE)
  - SERVO = 0
  - PWM counters = 0
  - miss count = 0
  - first flag = 1
- FSM states and STAT encoding:
  - IDLE (000): MODE_AUTO=1 → MOVE; also sets first = 1, miss = 0, AXIS = 0.
  - MOVE (001): POS[AXIS] ± STEP according to DIR[AXIS], saturating at 0 and 2^POS_W−1. If the step clamps at a limit, DIR[AXIS] inverts in the same cycle. → SETTLE with the settle counter cleared.
  - SETTLE (010): counts SETTLE_CYC cycles → SAMPLE.
  - SAMPLE (011): waits for V_valid, latches V_in → COMPARE. V_valid seen in any other state is ignored.
  - COMPARE (100):
    - first=1: max_V_in = sample, first = 0, miss = 0.
    - sample > max_V_in + HYST (ADC_W+1-bit compare): max_V_in = sample, miss = 0.
    - else: DIR[AXIS] inverts and miss increments. When miss reaches 2: miss = 0, AXIS = AXIS+1, wrapping NUM_AXES−1 → 0.
    - Then → MOVE.
- MODE_AUTO falling in any state: → IDLE next cycle. A latched sample is discarded; POS and DIR are held.
- Manual jog (only in IDLE with MODE_AUTO=0):
  - A rising edge of BTN_INC[k] adds STEP to POS[k]; a rising edge of BTN_DEC[k] subtracts STEP. Both saturate.
  - Rising edges of INC and DEC on the same axis in the same cycle: no change.
  - Held buttons produce exactly one step.
  - Edge-detect registers reset to 0, so a button already high when reset is released counts as an edge.
- PWM, per axis:
  - A shared counter runs 0..PWM_PERIOD−1.
  - At counter = 0 each axis loads its compare value cmp[k] = PWM_MIN + POS[k]·PWM_SCALE.
  - SERVO[k] = (counter < cmp[k]), registered.
  - A POS change mid-frame takes effect from the next frame only.

## Timing
- MOVE and COMPARE are one cycle each; SETTLE is exactly SETTLE_CYC cycles.
- SAMPLE is 1 cycle if V_valid is high on entry, otherwise unbounded.
- Minimum perturbation loop is SETTLE_CYC + 3 cycles.
- POS, DIR, AXIS and max_V_in are registered and update on the CLK edge that leaves the owning state.
- Manual jog: POS changes on the CLK edge after the button edge is detected, i.e. 1 cycle of edge-detect latency.
- SERVO lags the counter by 1 register stage.
- RST_N low forces all reset values immediately (asynchronously), including mid-SETTLE or mid-frame. Release is synchronous to CLK.

## Test plan
Simulation parameters: POS_W=4, STEP=1, HYST=2, SETTLE_CYC=4, PWM_PERIOD=64, PWM_MIN=8, PWM_SCALE=2, NUM_AXES=2.

- Reset: RST_N=0 → POS=8/8, DIR=11, STAT=000, SERVO=00. After release in manual mode, SERVO[k] is high 24 of every 64 cycles.
- Manual jog:
  - BTN_INC[0] held 3 cycles → POS0 = 9 only.
  - BTN_INC[1] and BTN_DEC[1] rising together → POS1 stays 8.
  - 10 INC edges on axis 0 from 8 → POS0 = 15, saturated.
- Auto climb: V_in = 50·POS0 with V_valid strobed in SAMPLE.
  - POS0 steps 9, 10 … 15 and max_V_in follows (450, 500 …).
  - At 15 the step clamps and DIR[0] inverts.
  - Two misses → AXIS = 1.
  - The STAT sequence observed is 001, 010 ×4, 011, 100.
- Flat input: V_in = 500 constant.
  - First COMPARE → max_V_in = 500.
  - Next two COMPAREs are misses: DIR[0] toggles twice, then AXIS = 1.
  - A sample of 502 is a miss; a sample of 503 is accepted.
- Mode/PWM boundary:
  - MODE_AUTO dropped in SETTLE → STAT = 000 next cycle, POS held, a later V_valid is ignored.
  - POS0 changed at counter = 30 → SERVO width changes only from the next frame.
- Reset mid-SETTLE: RST_N pulsed low → POS = 8, max_V_in = 0, STAT = 000 without waiting for a CLK edge.
